// File: rtl/chess_move_sequencer.sv
// Turn-based move controller: cursor, pick/drop sequencing and per-turn countdown.
// Move commits as two handshaked writes (dest, then source clear); WrEn holds until WrReady.
module chess_move_sequencer #(
    parameter int TURN_SECONDS = 60,
    parameter int TIME_W       = 8,
    parameter int INIT_X       = 2,
    parameter int INIT_Y       = 3
) (
    input  logic              clock,
    input  logic              resetApp,
    input  logic              KeyLeft,
    input  logic              KeyRight,
    input  logic              KeyUp,
    input  logic              KeyDown,
    input  logic              KeySelect,
    input  logic              TickEnable,
    output logic [5:0]        RdAddr,
    input  logic [7:0]        RdData,
    output logic              WrEn,
    output logic [5:0]        WrAddr,
    output logic [7:0]        WrData,
    input  logic              WrReady,
    output logic [5:0]        CursorIdx,
    output logic [5:0]        SourceIdx,
    output logic              PieceHeld,
    output logic              Turn,
    output logic [TIME_W-1:0] TimeLeft,
    output logic              MoveDone,
    output logic [3:0]        CapturedPiece,
    output logic              IllegalSel,
    output logic              TimeOut
);

    typedef enum logic [3:0] {
        SEL_SRC,
        WAIT_SRC,
        CHK_SRC,
        SEL_DST,
        WAIT_DST,
        CHK_DST,
        WR_DST,
        WR_SRC,
        COMMIT
    } state_t;

    localparam logic [TIME_W-1:0] TIME_RELOAD = TIME_W'(TURN_SECONDS);
    localparam logic [2:0]        X_RESET     = 3'(INIT_X);
    localparam logic [2:0]        Y_RESET     = 3'(INIT_Y);

    state_t     state;
    logic [2:0] cur_x;
    logic [2:0] cur_y;
    logic [3:0] held_piece;
    logic       in_sel;
    logic       timer_live;
    logic       expire;
    logic       own_piece;

    assign CursorIdx  = {cur_y, cur_x};
    assign in_sel     = (state == SEL_SRC) || (state == SEL_DST);
    assign timer_live = in_sel || (state == WAIT_SRC) || (state == CHK_SRC) ||
                        (state == WAIT_DST) || (state == CHK_DST);
    assign expire     = timer_live && TickEnable && (TimeLeft == TIME_W'(1));
    assign own_piece  = (RdData[3:0] != 4'h0) && (RdData[3] == Turn);

    always_ff @(posedge clock) begin
        if (resetApp) begin
            state         <= SEL_SRC;
            cur_x         <= X_RESET;
            cur_y         <= Y_RESET;
            RdAddr        <= {Y_RESET, X_RESET};
            SourceIdx     <= 6'd0;
            held_piece    <= 4'h0;
            PieceHeld     <= 1'b0;
            Turn          <= 1'b0;
            TimeLeft      <= TIME_RELOAD;
            WrEn          <= 1'b0;
            WrAddr        <= 6'd0;
            WrData        <= 8'h00;
            MoveDone      <= 1'b0;
            CapturedPiece <= 4'h0;
            IllegalSel    <= 1'b0;
            TimeOut       <= 1'b0;
        end else begin
            MoveDone   <= 1'b0;
            IllegalSel <= 1'b0;
            TimeOut    <= 1'b0;

            if (in_sel) begin
                RdAddr <= CursorIdx;
            end

            // Select owns the cycle; otherwise one direction key by priority.
            if (in_sel && !KeySelect) begin
                if (KeyLeft) begin
                    cur_x <= cur_x - 3'd1;
                end else if (KeyRight) begin
                    cur_x <= cur_x + 3'd1;
                end else if (KeyUp) begin
                    cur_y <= cur_y + 3'd1;
                end else if (KeyDown) begin
                    cur_y <= cur_y - 3'd1;
                end
            end

            if (timer_live && TickEnable && !expire) begin
                TimeLeft <= TimeLeft - TIME_W'(1);
            end

            if (expire) begin
                TimeOut   <= 1'b1;
                Turn      <= ~Turn;
                PieceHeld <= 1'b0;
                TimeLeft  <= TIME_RELOAD;
                state     <= SEL_SRC;
            end else begin
                case (state)
                    SEL_SRC: if (KeySelect) state <= WAIT_SRC;
                    WAIT_SRC: state <= CHK_SRC;
                    CHK_SRC: begin
                        if (own_piece) begin
                            SourceIdx  <= RdAddr;
                            held_piece <= RdData[3:0];
                            PieceHeld  <= 1'b1;
                            state      <= SEL_DST;
                        end else begin
                            IllegalSel <= 1'b1;
                            state      <= SEL_SRC;
                        end
                    end
                    SEL_DST: if (KeySelect) state <= WAIT_DST;
                    WAIT_DST: state <= CHK_DST;
                    CHK_DST: begin
                        if (RdAddr == SourceIdx) begin
                            PieceHeld <= 1'b0;
                            state     <= SEL_SRC;
                        end else if (own_piece) begin
                            IllegalSel <= 1'b1;
                            state      <= SEL_DST;
                        end else begin
                            CapturedPiece <= RdData[3:0];
                            WrEn          <= 1'b1;
                            WrAddr        <= RdAddr;
                            WrData        <= {4'h0, held_piece};
                            state         <= WR_DST;
                        end
                    end
                    WR_DST: begin
                        if (WrReady) begin
                            WrAddr <= SourceIdx;
                            WrData <= 8'h00;
                            state  <= WR_SRC;
                        end
                    end
                    WR_SRC: begin
                        if (WrReady) begin
                            WrEn  <= 1'b0;
                            state <= COMMIT;
                        end
                    end
                    COMMIT: begin
                        MoveDone  <= 1'b1;
                        Turn      <= ~Turn;
                        PieceHeld <= 1'b0;
                        TimeLeft  <= TIME_RELOAD;
                        state     <= SEL_SRC;
                    end
                    default: state <= SEL_SRC;
                endcase
            end
        end
    end

endmodule

// File: doc/chess_move_sequencer.md
Name: chess_move_sequencer

Overview:
- Turn-based move controller that sequences the shared chess board layout store (64 squares × 8 bits).
- Owns the selection cursor and tracks whose turn it is.
- Reads the source and destination squares through a 1-cycle-latency read port, then commits a move as two handshaked writes: destination first, then source cleared.
- Runs the per-turn countdown for the timed game. Sits between the key debouncers / 1 Hz tick generator and the layout store. Move-legality rules are out of scope; they belong to a separate block.

Parameters:
- TURN_SECONDS, 60, per-move time budget in ticks; reload value of TimeLeft.
- TIME_W, 8, width of TimeLeft; TURN_SECONDS must be < 2^TIME_W.
- INIT_X, 2, cursor column after reset.
- INIT_Y, 3, cursor row after reset.

Ports:
- clock  in  1  system clock
- resetApp  in  1  synchronous, active-high reset
- KeyLeft  in  1  single-cycle debounced key pulse
- KeyRight  in  1  single-cycle debounced key pulse
- KeyUp  in  1  single-cycle debounced key pulse
- KeyDown  in  1  single-cycle debounced key pulse
- KeySelect  in  1  single-cycle pick/drop pulse
- TickEnable  in  1  1-cycle pulse per second
- RdAddr  out  6  registered read address into the layout store
- RdData  in  8  square contents for RdAddr, valid 1 cycle after RdAddr changes
- WrEn  out  1  write request, held until accepted
- WrAddr  out  6  write square index
- WrData  out  8  write square contents
- WrReady  in  1  store accepts the write in any cycle where WrEn && WrReady
- CursorIdx  out  6  Y*8+X
- SourceIdx  out  6  square of the held piece
- PieceHeld  out  1  a source piece has been picked up
- Turn  out  1  0 = white, 1 = black
- TimeLeft  out  TIME_W  remaining ticks for the current turn
- MoveDone  out  1  1-cycle pulse on move commit
- CapturedPiece  out  4  piece code overwritten at the destination; valid with MoveDone, 0 if none
- IllegalSel  out  1  1-cycle pulse on a rejected select
- TimeOut  out  1  1-cycle pulse on turn expiry

Behaviour:
- Clock and reset: one clock. Reset is synchronous, active-high, sampled on the rising edge of clock.
- Square encoding:
  - [3:0] piece code: 0 = empty; bit3 = colour (0 white, 1 black).
  - [7:4] is highlight, owned by the display path. The sequencer always writes [7:4] = 0.
- Reset values:
  - State SEL_SRC; cursor X = INIT_X, Y = INIT_Y (CursorIdx = 26); RdAddr = 26.
  - SourceIdx = 0, PieceHeld = 0, Turn = 0, TimeLeft = TURN_SECONDS.
  - All pulses, WrEn, WrAddr, WrData and CapturedPiece = 0.
  - Reset mid-write drops WrEn the next cycle. A partially committed move is not rolled back.
- Cursor:
  - Moves only in SEL_SRC and SEL_DST.
  - Priority Left > Right > Up > Down; one key acted on per cycle.
  - X and Y are 3-bit and wrap modulo 8 (X = 0 with Left gives 7; Y = 7 with Up gives 0).
  - In SEL states RdAddr <= CursorIdx every cycle. In all other states RdAddr is frozen.
- States:
  - SEL_SRC: KeySelect (takes precedence over a direction key in the same cycle) → WAIT_SRC.
  - WAIT_SRC: 1 cycle, for read latency → CHK_SRC.
  - CHK_SRC:
    - If RdData[3:0] != 0 and RdData[3] == Turn: SourceIdx <= RdAddr, latch the piece, PieceHeld <= 1 → SEL_DST.
    - Otherwise pulse IllegalSel → SEL_SRC.
  - SEL_DST: KeySelect → WAIT_DST (1 cycle) → CHK_DST.
  - CHK_DST:
    - If RdAddr == SourceIdx: cancel. PieceHeld <= 0 → SEL_SRC, no pulse.
    - Else if the destination holds an own-colour piece: pulse IllegalSel, stay holding → SEL_DST.
    - Else latch the destination code into CapturedPiece → WR_DST.
  - WR_DST: WrEn = 1, WrAddr = destination, WrData = {4'h0, held piece}. On WrEn && WrReady → WR_SRC.
  - WR_SRC: WrEn = 1, WrAddr = SourceIdx, WrData = 8'h00. On accept → COMMIT.
  - COMMIT: pulse MoveDone, toggle Turn, PieceHeld <= 0, TimeLeft <= TURN_SECONDS → SEL_SRC.
  - Minimum move latency from the second KeySelect to MoveDone: 5 cycles with WrReady tied high.
- Write handshake:
  - WrAddr and WrData are stable while WrEn is high.
  - WrEn deasserts in the cycle after the final accept.
  - No write is ever issued outside WR_DST and WR_SRC.
- Timer:
  - Decrements on TickEnable in SEL, WAIT and CHK states. Frozen in WR_DST, WR_SRC and COMMIT.
  - When TimeLeft == 1 and TickEnable arrives in those states:
    - pulse TimeOut, toggle Turn, PieceHeld <= 0, TimeLeft <= TURN_SECONDS → SEL_SRC;
    - TimeOut wins over a same-cycle KeySelect.
  - A tick and a direction key in the same cycle both take effect.

Test Plan:
- Reset, then KeyLeft ×3 and KeyUp ×5 → CursorIdx goes 26→25→24→31 (X wraps to 7), then Y steps 3→4→5→6→7→0, ending at CursorIdx = 7.
- Cursor at 12 with RdData = 8'h01, KeySelect; then cursor at 28 with RdData = 8'h00, KeySelect, WrReady high → writes (28, 8'h01) then (12, 8'h00); MoveDone 5 cycles after the second select; Turn = 1; CapturedPiece = 0.
- Black holds a piece at 52; destination 44 contains 8'h03; WrReady low for 4 cycles → WrEn held with WrAddr = 44 stable; after accept, square 52 is cleared; CapturedPiece = 3.
- With Turn = 0, select a square holding 8'h09 → IllegalSel pulse, PieceHeld = 0. Then select an own piece and select the same square again → cancel, no writes, Turn unchanged.
- TURN_SECONDS = 3 with 3 TickEnable pulses while holding a piece → TimeOut on the third tick, Turn toggles, PieceHeld = 0, TimeLeft = 3, no writes.
- resetApp asserted during WR_SRC → next cycle WrEn = 0, state SEL_SRC, CursorIdx = 26, Turn = 0.
